// File: rtl/sram_mem_controller.sv
// Sequencer that turns one 32-bit pipeline load/store into two 16-bit SRAM
// half-accesses (low half, then high half), stalling the pipeline via ready.
module sram_mem_controller #(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] DATA_BASE     = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  localparam int            CW   = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [16:0]   idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [17:0]   addr_q, addr_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [16:0]   idx_in;
  logic          req;
  logic          last_beat;
  logic          dq_oe;

  // Word index of the SRAM window; offset bits outside [18:2] are discarded.
  assign idx_in    = 17'((address - DATA_BASE) >> 2);
  assign req       = mem_r_en | mem_w_en;
  assign last_beat = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
          wr_d    = mem_w_en;
          idx_d   = idx_in;
          wdata_d = wr_data;
          addr_d  = {idx_in, 1'b0};
          cnt_d   = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (last_beat) begin
          if (!wr_q) rdata_d[15:0] = SRAM_DQ;
          cnt_d   = '0;
          addr_d  = {idx_q, 1'b1};
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (last_beat) begin
          if (!wr_q) rdata_d[31:16] = SRAM_DQ;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  // The bus is only ever driven while a write half-access holds the pins.
  assign dq_oe     = wr_q && ((state_q == LOW) || (state_q == HIGH));
  assign SRAM_DQ   = dq_oe ? ((state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;
  assign SRAM_WE_N = ~dq_oe;
  assign SRAM_ADDR = addr_q;
  assign read_data = rdata_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: an SRAM model on the pins plus a word-level
// reference memory; directed cases followed by randomized transactions.
module tb_sram_mem_controller;

  localparam int          A        = 2;
  localparam logic [31:0] BASE     = 32'd1024;
  localparam int          DONE_IDX = 2 * A + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;

  int          checks   = 0;
  int          failures = 0;
  longint      cyc_cnt  = 0;
  longint      done_cyc = 0;

  logic [15:0] sram [0:262143];
  logic [31:0] ref_words [int];
  int          keys [$];
  logic [31:0] last_rd = '0;
  logic [17:0] last_alo, last_ahi;

  sram_mem_controller #(.ACCESS_CYCLES(A), .DATA_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .wr_data(wr_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Asynchronous SRAM: outputs data whenever not being written.
  assign SRAM_DQ = (SRAM_WE_N && !SRAM_OE_N && !SRAM_CE_N) ? sram[SRAM_ADDR] : 16'hzzzz;
  always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_DQ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("comparison %s", tag);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) & 32'h1FFFF);
  endfunction

  // Drives one request and watches the pins each cycle until ready rises.
  task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input bit drop, output int lat, output int bad, output logic [31:0] rd,
                      output logic [17:0] alo, output logic [17:0] ahi);
    int c;
    int idx;
    bit done;
    logic [17:0] ea;
    logic [15:0] ed;
    idx = idx_of(a);
    mem_r_en = r; mem_w_en = w; address = a; wr_data = d;
    c = 0; done = 0; bad = 0; lat = -1; rd = '0; alo = '0; ahi = '0;
    while (!done && c < 40) begin
      @(negedge clk);
      if (c >= 1 && c <= 2 * A) begin
        ea = 18'(idx * 2 + ((c > A) ? 1 : 0));
        ed = (c > A) ? d[31:16] : d[15:0];
        if (SRAM_ADDR !== ea) bad++;
        if (c == 1) alo = SRAM_ADDR;
        if (c == A + 1) ahi = SRAM_ADDR;
        if (w) begin
          if (SRAM_WE_N !== 1'b0 || SRAM_DQ !== ed) bad++;
        end else if (SRAM_WE_N !== 1'b1 || SRAM_DQ !== sram[SRAM_ADDR]) bad++;
      end else if (SRAM_WE_N !== 1'b1 || SRAM_DQ !== sram[SRAM_ADDR]) bad++;
      if (ready === 1'b1) begin
        done = 1; lat = c; rd = read_data; done_cyc = cyc_cnt;
      end
      @(posedge clk); #1;
      if (drop && c == 0) begin mem_r_en = 0; mem_w_en = 0; end
      c++;
    end
    mem_r_en = 0; mem_w_en = 0;
  endtask

  task automatic op(input string tag, input logic r, input logic w, input logic [31:0] a,
                    input logic [31:0] d, input bit drop);
    int lat, bad, idx;
    logic [31:0] rd, exp;
    logic [17:0] alo, ahi;
    idx = idx_of(a);
    xfer(r, w, a, d, drop, lat, bad, rd, alo, ahi);
    if (w) begin
      ref_words[idx] = d;
      exp = last_rd;
    end else begin
      exp = ref_words.exists(idx) ? ref_words[idx] : 32'h0;
      last_rd = exp;
    end
    last_alo = alo; last_ahi = ahi;
    chk({tag, ".done_cycle"}, lat, DONE_IDX);
    chk({tag, ".pin_errors"}, bad, 0);
    chk({tag, ".read_data"}, rd, exp);
  endtask

  initial begin
    longint d1;
    int id;
    logic [31:0] a;
    logic rr, ww;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset.ready", ready, 1'b1);
    chk("reset.read_data", read_data, 32'h0);
    chk("reset.we_n", SRAM_WE_N, 1'b1);
    chk("reset.addr", SRAM_ADDR, 18'h0);
    chk("reset.ties", {SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}, 4'b0000);

    op("wr_deadbeef", 0, 1, 32'd1024, 32'hDEADBEEF, 0);
    chk("wr_deadbeef.addr_lo", last_alo, 18'h0);
    chk("wr_deadbeef.addr_hi", last_ahi, 18'h1);
    op("rd_deadbeef", 1, 0, 32'd1024, 32'h0, 0);

    op("wr_top", 0, 1, BASE + 32'd4 * 32'd131071, 32'h13579BDF, 0);
    chk("wr_top.addr_lo", last_alo, 18'h3FFFE);
    chk("wr_top.addr_hi", last_ahi, 18'h3FFFF);
    op("rd_top", 1, 0, BASE + 32'd4 * 32'd131071, 32'h0, 0);
    op("wr_wrap", 0, 1, 32'd1020, 32'hCAFEF00D, 0);
    chk("wr_wrap.addr_lo", last_alo, 18'h3FFFE);
    op("rd_wrap", 1, 0, 32'd1020, 32'h0, 0);

    op("b2b_wr", 0, 1, 32'd1028, 32'h12345678, 0);
    d1 = done_cyc;
    op("b2b_rd", 1, 0, 32'd1028, 32'h0, 0);
    chk("b2b.done_spacing", 32'(done_cyc - d1), 2 * A + 2);

    op("both_en", 1, 1, 32'd1032, 32'hA5A5A5A5, 0);
    op("rd_both_en", 1, 0, 32'd1032, 32'h0, 0);
    op("drop_wr", 0, 1, 32'd1036, 32'h0F1E2D3C, 1);
    op("drop_rd", 1, 0, 32'd1036, 32'h0, 1);

    keys.push_back(0); keys.push_back(1); keys.push_back(131071); keys.push_back(2);
    keys.push_back(3);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        id = $urandom_range(131071, 0);
        a  = BASE + {13'($urandom), 17'(id), 2'($urandom)};
        rr = 1'($urandom);
        ww = 1'b1;
        if (!ref_words.exists(id)) keys.push_back(id);
      end else begin
        id = keys[$urandom_range(keys.size() - 1, 0)];
        a  = BASE + {13'($urandom), 17'(id), 2'($urandom)};
        rr = 1'b1;
        ww = 1'b0;
      end
      op($sformatf("rand%0d", i), rr, ww, a, $urandom, 1'($urandom));
    end

    op("pre_rst_wr", 0, 1, BASE + 32'd400, 32'h0BADF00D, 0);
    op("pre_rst_rd", 1, 0, BASE + 32'd400, 32'h0, 0);
    mem_w_en = 1'b1; address = BASE + 32'd4 * 32'd200; wr_data = $urandom;
    repeat (A + 1) @(posedge clk);
    #1;
    chk("rst_high.in_high_addr", SRAM_ADDR, 18'd401);
    rst = 1'b1; mem_w_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_high.ready", ready, 1'b1);
    chk("rst_high.we_n", SRAM_WE_N, 1'b1);
    chk("rst_high.read_data", read_data, 32'h0);
    chk("rst_high.addr", SRAM_ADDR, 18'h0);
    chk("rst_high.dq_released", SRAM_DQ, sram[0]);
    ref_words.delete(200);
    last_rd = '0;
    op("post_rst_rd", 1, 0, BASE + 32'd400, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Sequencer between the pipeline's memory stage and the 16-bit off-chip SRAM. Accepts one 32-bit word read or write per request, splits it into two 16-bit SRAM accesses (low half, then high half), and drives `ready` low to freeze the pipeline until the word transfer completes. It owns every SRAM pin; the memory stage only supplies the command and consumes `read_data` and `ready`.

## Interface
- ACCESS_CYCLES, 2: cycles each 16-bit half-access holds address, data and control on the SRAM pins (≥1).
- DATA_BASE, 1024: byte address mapped to SRAM word 0.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_r_en  in  1  read request; held stable by the pipeline while `ready`=0.
- mem_w_en  in  1  write request; held stable by the pipeline while `ready`=0.
- address  in  32  byte address (ALU result).
- wr_data  in  32  store data (Rm value).
- read_data  out  32  loaded word; valid in the DONE cycle and held until the next read completes.
- ready  out  1  0 = freeze pipeline; 1 = no request pending, or the current request completes this cycle.
- SRAM_DQ  inout  16  SRAM data bus; driven only during write half-accesses, otherwise high-Z.
- SRAM_ADDR  out  18  SRAM halfword address.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  tied 0.
- SRAM_WE_N  out  1  write strobe, active low.

## Operation
- Address map: off = address − DATA_BASE (32-bit modulo); idx = off[18:2] (17 bits). Low half at SRAM_ADDR = {idx,0}; high half at {idx,1}. off[1:0] and off[31:19] are ignored; addresses below DATA_BASE wrap silently.
- States: IDLE, LOW, HIGH, DONE.
- IDLE: when mem_r_en|mem_w_en, latch op (write if mem_w_en, else read), idx and wr_data; go to LOW. Both enables high is treated as a write.
- LOW: SRAM_ADDR={idx,0}; write: DQ=wr_data[15:0], WE_N=0; read: WE_N=1, DQ released. Stays ACCESS_CYCLES cycles (counter), then HIGH. On a read, DQ is sampled into read_data[15:0] on the last LOW cycle.
- HIGH: same as LOW, using {idx,1}, wr_data[31:16] and read_data[31:16].
- DONE: single cycle; ready=1; SRAM_WE_N=1, DQ released; go to IDLE.
- ready = ~(mem_r_en|mem_w_en) in IDLE; 0 in LOW and HIGH; 1 in DONE.
- Latched command: deasserting the enables mid-transfer does not abort; the transfer finishes and DONE still occurs.
- Writes leave read_data unchanged.
- Reset: state IDLE, counter 0, SRAM_ADDR 0, SRAM_WE_N 1, DQ high-Z, read_data 0, latched op/idx/data 0. Reset in any state aborts immediately; no partial-write rollback.

## Timing
- Request first seen in IDLE at cycle 0, with ready=0 that cycle. LOW covers cycles 1..A and HIGH covers A+1..2A, where A=ACCESS_CYCLES. DONE is cycle 2A+1. The pipeline advances on the edge ending DONE.
- Latency is 2A+2 cycles per access (6 at the default A=2). Back-to-back requests: the next request is seen in IDLE on the cycle after DONE.
- SRAM_WE_N is never low in IDLE or DONE. SRAM_ADDR changes only on LOW/HIGH entry or on reset.

## Test plan
- Write 0xDEADBEEF at address 1024 (A=2): ready low for cycles 0–4 and high at cycle 5. WE_N low cycles 1–4. ADDR=0 with DQ=0xBEEF, then ADDR=1 with DQ=0xDEAD.
- Read address 1024 after that write: read_data=0xDEADBEEF and ready=1 exactly at cycle 5. DQ is high-Z throughout.
- Boundary address 1024+4·131071: halves at SRAM 0x3FFFE and 0x3FFFF. Address 1020 wraps to idx 0x1FFFF.
- Back-to-back: write 0x12345678 at 1028, then read 1028 with no idle cycle. Second DONE falls 6 cycles after the first, with read_data=0x12345678.
- Both enables high with wr_data=0xA5A5A5A5: a write occurs, and read_data keeps its previous value.
- rst asserted during HIGH: next cycle is IDLE with WE_N=1, DQ high-Z, read_data=0. Enables dropped during LOW: the transfer still completes and DONE is asserted.
